// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the radix-2 Montgomery multiplier.
// The ECDSA controller imports the same operand width from here.
package mont_pkg;

    localparam int unsigned N  = 381;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mont_iter_step.sv
// One radix-2 Montgomery iteration: add a_bit*B, make the sum even with M, halve.
// Kept separate so the two chained adders can be retimed or made carry-save later.
module mont_iter_step
    import mont_pkg::*;
(
    input  logic [N+1:0] c,
    input  logic [N-1:0] b,
    input  logic [N-1:0] m,
    input  logic         a_bit,
    output logic [N+1:0] c_next
);

    logic [N+1:0] sum_b;
    logic [N+1:0] sum_m;

    // Sums stay N+2 bits wide so nothing is lost before the exact divide by two.
    always_comb begin
        sum_b  = c + (a_bit ? {2'b00, b} : '0);
        sum_m  = sum_b + (sum_b[0] ? {2'b00, m} : '0);
        c_next = sum_m >> 1;
    end

endmodule

// File: rtl/mont_mul_radix2.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-N mod m.
// N loop cycles, one conditional subtraction, one done cycle; latency is data independent.
module mont_mul_radix2
    import mont_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  m_reg;
    logic [N+1:0]  c_reg;
    logic [N+1:0]  c_step;
    logic [N-1:0]  c_final;
    logic [CW-1:0] i_reg;
    logic          last_iter;

    mont_iter_step u_step (
        .c      (c_reg),
        .b      (b_reg),
        .m      (m_reg),
        .a_bit  (a_reg[i_reg]),
        .c_next (c_step)
    );

    assign last_iter = (i_reg == CW'(N - 1));

    // The loop leaves C < 2M, so a single subtraction fully reduces it.
    assign c_final = (c_reg >= {2'b00, m_reg}) ? N'(c_reg - {2'b00, m_reg})
                                                : c_reg[N-1:0];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOOP;
            LOOP:    if (last_iter) state_next = SUB;
            SUB:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            m_reg  <= '0;
            c_reg  <= '0;
            i_reg  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        m_reg <= in_m;
                        c_reg <= '0;
                        i_reg <= '0;
                    end
                end
                LOOP: begin
                    c_reg <= c_step;
                    i_reg <= i_reg + 1'b1;
                end
                SUB: begin
                    result <= c_final;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_radix2.sv
// Randomised and directed bench for mont_mul_radix2 with a queue-based scoreboard.
// Expected results come from plain modular arithmetic: a*b*(2^-1)^N mod m.
module tb_mont_mul_radix2;
    import mont_pkg::*;

    localparam logic [N-1:0] BLS_P =
        381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    mont_mul_radix2 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // 2^-N mod m by repeated modular halving, then two wide mod-multiplies.
    function automatic logic [N-1:0] ref_mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [N-1:0] m);
        logic [N:0]     h;
        logic [2*N-1:0] wa;
        logic [2*N-1:0] wb;
        logic [2*N-1:0] wm;
        logic [2*N-1:0] wh;
        logic [2*N-1:0] prod;
        h = 1;
        for (int k = 0; k < N; k++) begin
            h = h[0] ? ((h + {1'b0, m}) >> 1) : (h >> 1);
        end
        wa   = {{N{1'b0}}, a};
        wb   = {{N{1'b0}}, b};
        wm   = {{N{1'b0}}, m};
        wh   = {{(N-1){1'b0}}, h};
        prod = (wa * wb) % wm;
        prod = (prod * wh) % wm;
        return prod[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_wide();
        logic [383:0] t;
        for (int k = 0; k < 12; k++) begin
            t[k*32 +: 32] = $urandom;
        end
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_modulus();
        logic [N-1:0] m;
        m        = rand_wide();
        m[N-1]   = 1'b0;
        m[0]     = 1'b1;
        m[N-2]   = ($urandom_range(0, 3) != 0);
        m[8]     = 1'b1;
        return m;
    endfunction

    task automatic check_output(input string name, input logic [N-1:0] actual,
                                input logic [N-1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Bounded wait for done; counts rising edges, sampling 1 time unit after each.
    task automatic wait_done(input string name, output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout actual=no_done required=done", name);
        end
    endtask

    // Single start pulse; operands are scrambled right after capture.
    task automatic apply_stimulus(input string name, input logic [N-1:0] a,
                                  input logic [N-1:0] b, input logic [N-1:0] m);
        int edges;
        bit ok;
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        in_m  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(ref_mont(a, b, m));
        check_output({name, "_busy_start"}, N'(busy), N'(1));
        in_a = rand_wide();
        in_b = rand_wide();
        in_m = rand_wide();
        wait_done(name, edges, ok);
        if (ok) begin
            check_output({name, "_latency"}, N'(edges), N'(N + 1));
            @(posedge clk);
            #1;
            check_output({name, "_done_width"}, N'(done), N'(0));
            check_output({name, "_busy_end"}, N'(busy), N'(0));
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done actual=%0h required=no_done", result);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    errors++;
                    $display("[TB] FAIL result actual=%0h required=%0h", result, e);
                end
            end
        end
    end

    initial begin
        logic [N:0]   rbig;
        logic [N-1:0] rmod;
        logic [N-1:0] a1;
        logic [N-1:0] a2;
        logic [N-1:0] bb;
        logic [N-1:0] mm;
        int           edges;
        bit           ok;

        reset = 1'b1;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        in_m  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", N'(busy), N'(0));
        check_output("reset_done", N'(done), N'(0));
        check_output("reset_result", result, '0);
        @(negedge clk);
        reset = 1'b0;

        // Montgomery one for the BLS12-381 base field.
        rbig = {1'b1, {N{1'b0}}} % {1'b0, BLS_P};
        rmod = rbig[N-1:0];
        apply_stimulus("bls_one", rmod, rmod, BLS_P);

        apply_stimulus("m13_5x7", N'(5), N'(7), N'(13));
        apply_stimulus("m13_1x1", N'(1), N'(1), N'(13));
        apply_stimulus("m13_0x12", N'(0), N'(12), N'(13));

        // start held high: two back-to-back operations, in_a changed mid-flight.
        mm = rand_modulus();
        a1 = rand_wide() % mm;
        a2 = rand_wide() % mm;
        bb = rand_wide() % mm;
        @(negedge clk);
        in_a  = a1;
        in_b  = bb;
        in_m  = mm;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(ref_mont(a1, bb, mm));
        repeat (3) @(posedge clk);
        #1;
        in_a = a2;
        exp_q.push_back(ref_mont(a2, bb, mm));
        wait_done("hold_first", edges, ok);
        wait_done("hold_second", edges, ok);
        if (ok) check_output("hold_spacing", N'(edges), N'(N + 3));
        start = 1'b0;
        @(posedge clk);
        #1;
        check_output("hold_busy_end", N'(busy), N'(0));

        // Reset mid-operation: no done pulse, everything back to zero.
        @(negedge clk);
        in_a  = N'(5);
        in_b  = N'(7);
        in_m  = N'(13);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_output("midreset_busy", N'(busy), N'(0));
        check_output("midreset_done", N'(done), N'(0));
        check_output("midreset_result", result, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (N + 5) @(posedge clk);
        #1;
        check_output("midreset_idle_busy", N'(busy), N'(0));
        check_output("midreset_idle_result", result, '0);
        apply_stimulus("after_reset", N'(5), N'(7), N'(13));

        // Random vectors with odd moduli below 2^(N-1).
        for (int v = 0; v < 60; v++) begin
            mm = rand_modulus();
            a1 = rand_wide() % mm;
            bb = rand_wide() % mm;
            apply_stimulus("random", a1, bb, mm);
        end

        repeat (3) @(posedge clk);
        check_output("queue_drained", N'(exp_q.size()), N'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
